// File: rtl/ttt_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ttt_pkg
// Description : Shared types and constants for the tic-tac-toe controller.
//               Cell encoding, game FSM states, board geometry and a helper
//               that extracts one cell from the flat board vector.
// Revision    : 1.0 - initial release
// ============================================================================
package ttt_pkg;

  typedef logic [1:0] cell_t;

  localparam cell_t EMPTY  = 2'b00;
  localparam cell_t MARK_X = 2'b01;
  localparam cell_t MARK_O = 2'b10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_MOVE = 2'd1,
    CHECK     = 2'd2,
    DONE      = 2'd3
  } game_state_t;

  localparam int NUM_CELLS = 9;
  localparam int BOARD_W   = 2 * NUM_CELLS;

  // Cell i lives at board[2i+1:2i], row-major.
  function automatic cell_t cell_at(input logic [BOARD_W-1:0] b, input int i);
    return b[2*i +: 2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ttt_line_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ttt_line_checker
// Description : Purely combinational scan of the 8 winning lines (3 rows,
//               3 columns, 2 diagonals) for three equal non-empty marks.
// Ports       : board    in  18  flat board, cell i at [2i+1:2i]
//               win      out  1  a completed line exists
//               win_mark out  2  mark on the completed line (EMPTY if none)
// Revision    : 1.0 - initial release
// ============================================================================
module ttt_line_checker
  import ttt_pkg::*;
(
  input  logic [BOARD_W-1:0] board,
  output logic               win,
  output cell_t              win_mark
);

  // Cell indices of each line: rows, columns, then the two diagonals.
  localparam logic [3:0] LINE_A [8] = '{4'd0, 4'd3, 4'd6, 4'd0, 4'd1, 4'd2, 4'd0, 4'd2};
  localparam logic [3:0] LINE_B [8] = '{4'd1, 4'd4, 4'd7, 4'd3, 4'd4, 4'd5, 4'd4, 4'd4};
  localparam logic [3:0] LINE_C [8] = '{4'd2, 4'd5, 4'd8, 4'd6, 4'd7, 4'd8, 4'd8, 4'd6};

  always_comb begin
    win      = 1'b0;
    win_mark = EMPTY;
    for (int l = 0; l < 8; l++) begin
      if (!win &&
          cell_at(board, int'(LINE_A[l])) != EMPTY &&
          cell_at(board, int'(LINE_A[l])) == cell_at(board, int'(LINE_B[l])) &&
          cell_at(board, int'(LINE_A[l])) == cell_at(board, int'(LINE_C[l]))) begin
        win      = 1'b1;
        win_mark = cell_at(board, int'(LINE_A[l]));
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ttt_game_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ttt_game_controller
// Description : Two-player tic-tac-toe sequencer. Alternates X/O turns,
//               rejects illegal moves, auto-places on per-turn timeout into
//               the lowest free cell, and detects win or draw.
// Ports       : clk         in   1  system clock
//               rst_n       in   1  synchronous active-low reset
//               start       in   1  begin new game (IDLE or DONE only)
//               move_valid  in   1  single-cycle move strobe
//               move_idx    in   4  target cell 0..8, row-major
//               board       out 18  cell i at [2i+1:2i]; 00/01 X/10 O
//               turn        out  1  0 = X to move, 1 = O to move
//               illegal     out  1  one-cycle pulse, move rejected
//               timeout     out  1  one-cycle pulse, auto-placement done
//               game_over   out  1  high while in DONE
//               winner      out  2  01 X, 10 O, 00 draw/none
// Revision    : 1.0 - initial release
// ============================================================================
module ttt_game_controller
  import ttt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 500_000_000,
  parameter int TW             = 29
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               move_valid,
  input  logic [3:0]         move_idx,
  output logic [BOARD_W-1:0] board,
  output logic               turn,
  output logic               illegal,
  output logic               timeout,
  output logic               game_over,
  output logic [1:0]         winner
);

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    FULL_COUNT = 4'(NUM_CELLS);

  game_state_t        state, state_nx;
  logic [BOARD_W-1:0] board_nx;
  logic               turn_nx;
  logic               illegal_nx;
  logic               timeout_nx;
  cell_t              winner_nx;
  logic [TW-1:0]      timer, timer_nx;
  logic [3:0]         move_count, count_nx;

  logic               line_win;
  cell_t              line_mark;
  logic               cell_busy;
  logic               move_ok;
  logic               place_en;
  logic [3:0]         place_idx;
  logic [3:0]         free_idx;
  cell_t              mover_mark;

  // Priority encoder: lowest-index empty cell. Scanning downward lets the
  // last (lowest) hit win.
  function automatic logic [3:0] lowest_free(input logic [BOARD_W-1:0] b);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = NUM_CELLS - 1; i >= 0; i--) begin
      if (cell_at(b, i) == EMPTY) idx = 4'(i);
    end
    return idx;
  endfunction

  ttt_line_checker u_line_checker (
    .board    (board),
    .win      (line_win),
    .win_mark (line_mark)
  );

  // Occupancy of the strobed cell; indices above 8 never match here and are
  // rejected separately by the range check.
  always_comb begin
    cell_busy = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (move_idx == 4'(i)) cell_busy = (cell_at(board, i) != EMPTY);
    end
  end

  assign move_ok    = (move_idx < FULL_COUNT) && !cell_busy;
  assign mover_mark = turn ? MARK_O : MARK_X;
  assign free_idx   = lowest_free(board);
  assign game_over  = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      board      <= '0;
      turn       <= 1'b0;
      illegal    <= 1'b0;
      timeout    <= 1'b0;
      winner     <= EMPTY;
      timer      <= '0;
      move_count <= '0;
    end else begin
      state      <= state_nx;
      board      <= board_nx;
      turn       <= turn_nx;
      illegal    <= illegal_nx;
      timeout    <= timeout_nx;
      winner     <= winner_nx;
      timer      <= timer_nx;
      move_count <= count_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    board_nx   = board;
    turn_nx    = turn;
    illegal_nx = 1'b0;
    timeout_nx = 1'b0;
    winner_nx  = winner;
    timer_nx   = timer;
    count_nx   = move_count;
    place_en   = 1'b0;
    place_idx  = 4'd0;

    case (state)
      IDLE: begin
        board_nx = '0;
        if (start) begin
          state_nx  = WAIT_MOVE;
          turn_nx   = 1'b0;
          timer_nx  = '0;
          count_nx  = '0;
          winner_nx = EMPTY;
        end
      end

      WAIT_MOVE: begin
        timer_nx = timer + TW'(1);
        if (move_valid && move_ok) begin
          // A legal strobe beats a coinciding timeout.
          place_en  = 1'b1;
          place_idx = move_idx;
        end else begin
          illegal_nx = move_valid;
          if (timer == TIMER_LAST) begin
            timeout_nx = 1'b1;
            place_en   = 1'b1;
            place_idx  = free_idx;
          end
        end
        if (place_en) begin
          count_nx = move_count + 4'd1;
          state_nx = CHECK;
        end
      end

      CHECK: begin
        if (line_win) begin
          state_nx  = DONE;
          winner_nx = line_mark;
        end else if (move_count == FULL_COUNT) begin
          state_nx  = DONE;
          winner_nx = EMPTY;
        end else begin
          state_nx = WAIT_MOVE;
          turn_nx  = ~turn;
          timer_nx = '0;
        end
      end

      DONE: begin
        if (start) begin
          state_nx  = WAIT_MOVE;
          board_nx  = '0;
          winner_nx = EMPTY;
          turn_nx   = 1'b0;
          timer_nx  = '0;
          count_nx  = '0;
        end
      end

      default: state_nx = IDLE;
    endcase

    if (place_en) begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        if (place_idx == 4'(i)) board_nx[2*i +: 2] = mover_mark;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ttt_game_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ttt_game_controller
// Description : Self-checking bench for ttt_game_controller. Per-cycle
//               vectors hold inputs and expected outputs; expected outputs
//               go through a scoreboard queue and are compared one cycle on.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ttt_game_controller;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst_n, start, move_valid;
  logic [3:0]  move_idx;
  logic [17:0] board;
  logic        turn, illegal, timeout, game_over;
  logic [1:0]  winner;

  always #5 clk = ~clk;

  ttt_game_controller #(.TIMEOUT_CYCLES(TO), .TW(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .move_valid (move_valid),
    .move_idx   (move_idx),
    .board      (board),
    .turn       (turn),
    .illegal    (illegal),
    .timeout    (timeout),
    .game_over  (game_over),
    .winner     (winner)
  );

  typedef struct packed {
    logic [17:0] board;
    logic        turn;
    logic        illegal;
    logic        timeout;
    logic        game_over;
    logic [1:0]  winner;
  } obs_t;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       start;
    logic       mv;
    logic [3:0] idx;
    obs_t       exp;
  } vec_t;

  vec_t vecs[$];
  obs_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   immediate;

  // Bench-side game model: occupancy masks for X and O plus whose turn.
  logic [8:0] xm, om;
  logic       t;

  function automatic logic [17:0] bd(input logic [8:0] x, input logic [8:0] o);
    logic [17:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) begin
      if (x[i]) b[2*i +: 2] = 2'b01;
      if (o[i]) b[2*i +: 2] = 2'b10;
    end
    return b;
  endfunction

  function automatic obs_t mk(input logic [17:0] b, input logic tn, input logic il,
                              input logic to, input logic go, input logic [1:0] w);
    obs_t o;
    o.board = b; o.turn = tn; o.illegal = il; o.timeout = to; o.game_over = go; o.winner = w;
    return o;
  endfunction

  task automatic apply(input vec_t v);
    obs_t got, want;
    rst_n      = v.rst_n;
    start      = v.start;
    move_valid = v.mv;
    move_idx   = v.idx;
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    got  = {board, turn, illegal, timeout, game_over, winner};
    want = sb.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got board=%05h turn=%b illegal=%b timeout=%b game_over=%b winner=%b, expected board=%05h turn=%b illegal=%b timeout=%b game_over=%b winner=%b",
               v.name, got.board, got.turn, got.illegal, got.timeout, got.game_over, got.winner,
               want.board, want.turn, want.illegal, want.timeout, want.game_over, want.winner);
    end
  endtask

  task automatic add(input string nm, input logic r, input logic s, input logic mv,
                     input logic [3:0] idx, input obs_t e);
    vec_t v;
    v.name = nm; v.rst_n = r; v.start = s; v.mv = mv; v.idx = idx; v.exp = e;
    if (immediate) apply(v);
    else vecs.push_back(v);
  endtask

  task automatic clr();
    xm = '0; om = '0; t = 1'b0;
  endtask

  task automatic idle_row(input string nm);
    add(nm, 1'b1, 1'b0, 1'b0, 4'd0, mk(bd(xm, om), t, 1'b0, 1'b0, 1'b0, 2'b00));
  endtask

  // Legal move: strobe cycle shows the mark, next cycle toggles turn or ends.
  task automatic add_move(input string nm, input int idx, input bit last, input logic [1:0] w);
    if (!t) xm[idx] = 1'b1;
    else    om[idx] = 1'b1;
    add(nm, 1'b1, 1'b0, 1'b1, 4'(idx), mk(bd(xm, om), t, 1'b0, 1'b0, 1'b0, 2'b00));
    if (last) begin
      add({nm, "_chk"}, 1'b1, 1'b0, 1'b0, 4'd0, mk(bd(xm, om), t, 1'b0, 1'b0, 1'b1, w));
    end else begin
      t = ~t;
      idle_row({nm, "_chk"});
    end
  endtask

  task automatic add_game(input string nm, input int mv[9], input int n, input logic [1:0] w);
    for (int k = 0; k < n; k++) add_move($sformatf("%s_m%0d", nm, k), mv[k], (k == n - 1), w);
  endtask

  task automatic add_start(input string nm);
    clr();
    add(nm, 1'b1, 1'b1, 1'b0, 4'd0, mk(18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; move_valid = 1'b0; move_idx = 4'd0;
    immediate = 1'b0;
    clr();

    // ---------------- table construction ----------------
    add("reset", 1'b0, 1'b0, 1'b0, 4'd0, mk(18'h0, 0, 0, 0, 0, 2'b00));
    add("idle_move_ignored", 1'b1, 1'b0, 1'b1, 4'd0, mk(18'h0, 0, 0, 0, 0, 2'b00));
    add_start("start_from_idle");

    add_game("xwin", '{0, 3, 1, 4, 2, 0, 0, 0, 0}, 5, 2'b01);
    add("xwin_board_const", 1'b1, 1'b0, 1'b0, 4'd0, mk(18'h00295, 0, 0, 0, 1, 2'b01));
    add("done_move_ignored", 1'b1, 1'b0, 1'b1, 4'd5, mk(bd(xm, om), 0, 0, 0, 1, 2'b01));
    add_start("start_in_done");

    add_move("ill_x4", 4, 0, 2'b00);
    add("ill_occupied", 1'b1, 1'b0, 1'b1, 4'd4, mk(bd(xm, om), 1, 1, 0, 0, 2'b00));
    idle_row("ill_pulse_clears");
    add("ill_idx9", 1'b1, 1'b0, 1'b1, 4'd9, mk(bd(xm, om), 1, 1, 0, 0, 2'b00));
    add_move("ill_o0", 0, 0, 2'b00);
    add("start_in_wait", 1'b1, 1'b1, 1'b0, 4'd0, mk(bd(xm, om), 0, 0, 0, 0, 2'b00));

    clr();
    add("mid_reset", 1'b0, 1'b0, 1'b0, 4'd0, mk(18'h0, 0, 0, 0, 0, 2'b00));
    add("post_reset_move", 1'b1, 1'b0, 1'b1, 4'd2, mk(18'h0, 0, 0, 0, 0, 2'b00));
    add_start("start_after_reset");

    add_game("draw", '{0, 1, 2, 4, 3, 5, 7, 6, 8}, 9, 2'b00);
    add_start("start_after_draw");
    add_game("lastwin", '{0, 1, 2, 4, 3, 5, 7, 8, 6}, 9, 2'b01);

    foreach (vecs[i]) apply(vecs[i]);

    // ---------------- timeout corner cases ----------------
    immediate = 1'b1;
    add_start("to_start");
    add_move("to_x0", 0, 0, 2'b00);
    for (int k = 0; k < TO - 1; k++) idle_row("to_o_wait");
    om[1] = 1'b1;
    add("to_fire", 1'b1, 1'b0, 1'b0, 4'd0, mk(bd(xm, om), 1, 0, 1, 0, 2'b00));
    t = 1'b0;
    idle_row("to_turn_back");

    // Legal strobe on the final cycle: strobed cell wins, no timeout pulse.
    for (int k = 0; k < TO - 1; k++) idle_row("to_x_wait");
    add_move("to_legal_on_last", 5, 0, 2'b00);

    // Illegal strobe on the final cycle: both pulses, lowest free cell (2).
    for (int k = 0; k < TO - 1; k++) idle_row("to_o_wait2");
    om[2] = 1'b1;
    add("to_illegal_on_last", 1'b1, 1'b0, 1'b1, 4'd0, mk(bd(xm, om), 1, 1, 1, 0, 2'b00));
    t = 1'b0;
    idle_row("to_illegal_chk");

    move_valid = 1'b0;
    start      = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
